// File: rtl/decode_scan.sv
// Binary-to-one-hot channel decoder with registered outputs, enable gating,
// optional active-low polarity and an autonomous dwell-timed scan mode.
module decode_scan #(
  parameter int SEL_W      = 2,
  parameter int N_OUT      = 4,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] y,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]    DLAST    = CW'(DWELL - 1);
  localparam logic [SEL_W-1:0] LAST     = SEL_W'(N_OUT - 1);
  localparam logic [SEL_W:0]   NOUT_X   = N_OUT[SEL_W:0];
  localparam logic [N_OUT-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [N_OUT-1:0] y_q, y_d;
  logic [SEL_W-1:0] idx_q, idx_d, eff;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  function automatic logic [N_OUT-1:0] onehot(input logic [SEL_W-1:0] v);
    logic [N_OUT-1:0] r;
    r = '0;
    for (int i = 0; i < N_OUT; i++) r[i] = (v == SEL_W'(i));
    return (ACTIVE_LOW != 0) ? ~r : r;
  endfunction

  // An out-of-range index left over from direct mode scans as the last channel.
  assign eff = ({1'b0, idx_q} >= NOUT_X) ? LAST : idx_q;

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    y_d    = INACTIVE;
    wrap_d = 1'b0;
    if (en) begin
      if (!mode) begin
        cnt_d = '0;
        if ({1'b0, sel} < NOUT_X) begin
          idx_d = sel;
          y_d   = onehot(sel);
        end
      end else if (cnt_q != DLAST) begin
        cnt_d = cnt_q + 1'b1;
        idx_d = eff;
        y_d   = onehot(eff);
      end else begin
        cnt_d = '0;
        if (eff == LAST) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = eff + 1'b1;
        end
        y_d = onehot(idx_d);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q    <= INACTIVE;
      idx_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decode_scan.sv
// Directed bench for decode_scan: a 4-channel DWELL=3 instance and a
// 3-channel DWELL=1 active-low instance sharing clock and reset.
module tb_decode_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_a = 1'b0, mode_a = 1'b0;
  logic [1:0] sel_a = '0;
  logic [3:0] y_a;
  logic [1:0] idx_a;
  logic       wrap_a;
  logic       en_b = 1'b0, mode_b = 1'b0;
  logic [1:0] sel_b = '0;
  logic [2:0] y_b;
  logic [1:0] idx_b;
  logic       wrap_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decode_scan #(.SEL_W(2), .N_OUT(4), .DWELL(3), .ACTIVE_LOW(0)) u_dut_a (
    .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .sel(sel_a),
    .y(y_a), .idx(idx_a), .wrap(wrap_a)
  );

  decode_scan #(.SEL_W(2), .N_OUT(3), .DWELL(1), .ACTIVE_LOW(1)) u_dut_b (
    .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .sel(sel_b),
    .y(y_b), .idx(idx_b), .wrap(wrap_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    int e;
    // reset state
    repeat (2) step();
    chk("rst_y_a", 32'(y_a), 32'h0);
    chk("rst_idx_a", 32'(idx_a), 32'h0);
    chk("rst_wrap_a", 32'(wrap_a), 32'h0);
    chk("rst_y_b", 32'(y_b), 32'h7);
    rst = 1'b0;

    // direct decode
    en_a = 1'b1; mode_a = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel_a = 2'(s);
      step();
      chk("dir_y", 32'(y_a), 32'(1) << s);
      chk("dir_idx", 32'(idx_a), 32'(s));
      chk("dir_wrap", 32'(wrap_a), 32'h0);
    end

    // asynchronous reset in the middle of a low phase
    sel_a = 2'd2;
    step();
    chk("pre_rst_y", 32'(y_a), 32'h4);
    #2 rst = 1'b1;
    #1;
    chk("arst_y", 32'(y_a), 32'h0);
    chk("arst_idx", 32'(idx_a), 32'h0);
    chk("arst_wrap", 32'(wrap_a), 32'h0);
    step();
    rst = 1'b0;

    // scan from idx 0: direct sel=0 gives the first dwell cycle
    sel_a = 2'd0;
    step();
    chk("scan0_y", 32'(y_a), 32'h1);
    mode_a = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      e = (k / 3) % 4;
      chk("scan_y", 32'(y_a), 32'(1) << e);
      chk("scan_idx", 32'(idx_a), 32'(e));
      chk("scan_wrap", 32'(wrap_a), (k == 12) ? 32'h1 : 32'h0);
    end

    // advance to idx 2 with one dwell cycle used beyond the first
    repeat (6) step();
    chk("gate_pre_y", 32'(y_a), 32'h4);
    en_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("gate_off_y", 32'(y_a), 32'h0);
      chk("gate_off_idx", 32'(idx_a), 32'h2);
    end
    en_a = 1'b1;
    step();
    chk("gate_on_y", 32'(y_a), 32'h4);
    step();
    chk("gate_next_y", 32'(y_a), 32'h8);
    chk("gate_next_idx", 32'(idx_a), 32'h3);

    // walk to idx 1, then mode switch
    repeat (6) step();
    chk("ms_pre_idx", 32'(idx_a), 32'h1);
    chk("ms_pre_y", 32'(y_a), 32'h2);
    mode_a = 1'b0; sel_a = 2'd3;
    step();
    chk("ms_dir_y", 32'(y_a), 32'h8);
    mode_a = 1'b1;
    step();
    chk("ms_hold1_y", 32'(y_a), 32'h8);
    step();
    chk("ms_hold2_y", 32'(y_a), 32'h8);
    chk("ms_hold2_wrap", 32'(wrap_a), 32'h0);
    step();
    chk("ms_wrap_y", 32'(y_a), 32'h1);
    chk("ms_wrap", 32'(wrap_a), 32'h1);

    // variant: N_OUT=3, DWELL=1, active-low
    en_b = 1'b1; mode_b = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      e = k % 3;
      chk("var_y", 32'(y_b), 32'(~(3'b001 << e) & 3'b111));
      chk("var_idx", 32'(idx_b), 32'(e));
      chk("var_wrap", 32'(wrap_b), (e == 0) ? 32'h1 : 32'h0);
    end
    mode_b = 1'b0; sel_b = 2'd1;
    step();
    chk("var_dir_y", 32'(y_b), 32'h5);
    sel_b = 2'd3;
    step();
    chk("var_oor_y", 32'(y_b), 32'h7);
    chk("var_oor_idx", 32'(idx_b), 32'h1);
    chk("var_oor_wrap", 32'(wrap_b), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_scan.md
Name: decode_scan

Overview:
- Parametrised binary-to-one-hot channel decoder with registered outputs; generalises the 2-to-4 select decoder to SEL_W select bits and N_OUT channels.
- Adds enable, optional active-low outputs and an autonomous scan mode that rotates the active channel every DWELL cycles.
- Drives the channel/digit enables of the 4-output multiplexor, either under direct select or self-scanning for multiplexed displays.

Parameters:
- SEL_W, 2, select/index width in bits.
- N_OUT, 4, number of output channels; 2 <= N_OUT <= 2**SEL_W.
- DWELL, 4, enabled cycles each channel stays active in scan mode; DWELL >= 1.
- ACTIVE_LOW, 0, 1 inverts every bit of y; "inactive" means all-ones.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  enable; 0 forces y inactive and freezes state.
- mode  input  1  0 = direct decode of sel, 1 = auto-scan.
- sel  input  SEL_W  channel select, used in direct mode only.
- y  output  N_OUT  registered one-hot channel enables, polarity per ACTIVE_LOW.
- idx  output  SEL_W  registered index of the current/last active channel.
- wrap  output  1  one-cycle pulse when the scan steps from N_OUT-1 to 0.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset (asynchronous, immediate, including mid-scan):
  - y = inactive (0 when ACTIVE_LOW=0, all-ones when ACTIVE_LOW=1).
  - idx = 0, dwell counter = 0, wrap = 0.
- After rst deasserts, the first clock edge operates normally.
- All outputs are registered. Decode latency is 1 cycle: sel sampled at edge k appears on y/idx after edge k.
- Internal dwell counter width is max(1, clog2(DWELL)).
- en=0 at an edge: y <= inactive, wrap <= 0; idx and dwell counter hold.
- Direct mode (mode=0, en=1), per edge:
  - sel < N_OUT: idx <= sel, y <= onehot(sel).
  - sel >= N_OUT: y <= inactive, idx holds.
  - In both cases the dwell counter is cleared and wrap <= 0.
- Scan mode (mode=1, en=1), per edge:
  - If counter < DWELL-1: counter++, idx holds, y <= onehot(idx), wrap <= 0.
  - If counter == DWELL-1: counter <= 0, idx <= (idx == N_OUT-1) ? 0 : idx+1, y <= onehot(new idx).
  - wrap <= 1 exactly on the edge where idx goes N_OUT-1 -> 0; otherwise wrap <= 0.
- DWELL=1: idx advances on every enabled edge.
- Mode change 0->1: scan starts from the current idx with counter 0. The current channel gets a full DWELL cycles before advancing.
- Mode change 1->0: the next edge loads sel directly; the scan counter is discarded.
- Entering scan with idx >= N_OUT (only possible if N_OUT < 2**SEL_W): treated as N_OUT-1, so the next step goes to 0 with wrap.
- en toggled off and back on in scan: resumes the same idx and counter value, with no skipped or repeated dwell cycles.
- Invariant: y is never multi-hot. It is either exactly one active bit or fully inactive.

Test Plan:
All cases use SEL_W=2, N_OUT=4, DWELL=3, ACTIVE_LOW=0 unless stated.
- Reset: assert rst mid-cycle with y=4'b0100 -> y=0, idx=0, wrap=0 immediately, without waiting for a clock edge.
- Direct decode: en=1, mode=0, sel=0,1,2,3 on consecutive edges -> y=0001,0010,0100,1000, each one cycle after its sel is applied; idx follows.
- Scan and wrap: en=1, mode=1 from idx=0 -> y holds 0001 for 3 cycles, then 0010, 0100, 1000 (3 cycles each). Then y returns to 0001 with wrap=1 for exactly one cycle; period is 12 cycles.
- Enable gating: in scan, drop en for 5 cycles in the middle of idx=2's dwell -> y=0000 during those cycles. On re-enable, y returns to 0100 for the remaining dwell cycles, then 1000.
- Mode switch: scan at idx=1, switch to mode=0 with sel=3 -> y=1000 on the next edge. Switch back to mode=1 -> channel 3 holds for 3 cycles, then wraps to 0001 with wrap=1.
- Parameter variant (N_OUT=3, DWELL=1, ACTIVE_LOW=1):
  - Scan -> y cycles 110,101,011 every cycle; wrap pulses on each 2->0 step.
  - Direct mode with sel=3 -> y=111 (inactive) and idx holds.
